// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate Wallace-tree MAC.
// Holds the FSM state enum, operand/product widths, the truncation mask
// that defines the approximation, and a 3:2 carry-save compressor helper.
package approx_mac_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // The approximation: every partial-product bit that lands in columns
  // 0..3 is discarded before reduction, so products are never over-estimated
  // and their low nibble is always zero.
  localparam logic [PROD_W-1:0] PP_KEEP_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } mac_state_t;

  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;

  // Row-wise full-adder compressor; carries leaving bit 15 are dropped,
  // which is exact because the true product always fits in 16 bits.
  function automatic csa_t csa(input logic [PROD_W-1:0] x,
                               input logic [PROD_W-1:0] y,
                               input logic [PROD_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/approx_wallace_mac_accumulator_mult.sv
// Approximate 8x8 unsigned Wallace-tree multiplier, purely combinational.
// Latency: 0 cycles. Backpressure: none (no state, no handshake).
// Ports: a_i, b_i operands; p_o 16-bit approximate product.
module approx_wallace_mac_accumulator_mult
  import approx_mac_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] pp [OP_W];

  for (genvar j = 0; j < OP_W; j++) begin : g_pp
    assign pp[j] = (b_i[j] ? (PROD_W'(a_i) << j) : '0) & PP_KEEP_MASK;
  end

  // Reduction tree: 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  csa_t l1_0, l1_1, l2_0, l2_1, l3_0, l4_0;

  assign l1_0 = csa(pp[0], pp[1], pp[2]);
  assign l1_1 = csa(pp[3], pp[4], pp[5]);
  assign l2_0 = csa(l1_0.s, l1_0.c, l1_1.s);
  assign l2_1 = csa(l1_1.c, pp[6], pp[7]);
  assign l3_0 = csa(l2_0.s, l2_0.c, l2_1.s);
  assign l4_0 = csa(l3_0.s, l3_0.c, l2_1.c);

  assign p_o = l4_0.s + l4_0.c;

endmodule

// File: rtl/approx_wallace_mac_accumulator.sv
// Framed multiply-accumulate over a stream of 8-bit operand pairs.
// Latency: accept at edge E, product registered at E, added at E+1; out_valid from E+1 after last accept.
// Backpressure: in_ready drops once all terms are accepted; result held in DONE until out_ready.
// Ports: clk/rst_n; start+num_terms open a frame; a,b/in_valid/in_ready operand stream;
//   result/overflow/out_valid/out_ready result port; busy high outside IDLE.
// Build option ACC_SAT_EN: saturate acc to all-ones on carry-out instead of wrapping.
module approx_wallace_mac_accumulator
  import approx_mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int SUM_W = ACC_W + 1;

  mac_state_t        state_q, state_d;
  logic [CNT_W-1:0]  num_terms_q, num_terms_d;
  logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;
  logic [CNT_W-1:0]  add_cnt_q, add_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic              p_vld_q, p_vld_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [PROD_W-1:0] prod;
  logic              accept;
  logic [SUM_W-1:0]  sum_w;
  logic [CNT_W-1:0]  add_cnt_inc;

  approx_wallace_mac_accumulator_mult u_mult (
    .a_i (a),
    .b_i (b),
    .p_o (prod)
  );

  // in_ready_q is only ever set in ACCUM, so no state qualifier is needed.
  assign accept      = in_valid & in_ready_q;
  assign sum_w       = {1'b0, acc_q} + SUM_W'(p_q);
  assign add_cnt_inc = add_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    num_terms_d  = num_terms_q;
    accept_cnt_d = accept_cnt_q;
    add_cnt_d    = add_cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    p_d          = p_q;
    p_vld_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_terms_d  = num_terms;
          accept_cnt_d = '0;
          add_cnt_d    = '0;
          acc_d        = '0;
          ovf_d        = 1'b0;
          state_d      = (num_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          p_d          = prod;
          p_vld_d      = 1'b1;
          accept_cnt_d = accept_cnt_q + 1'b1;
        end
        if (p_vld_q) begin
          ovf_d     = ovf_q | sum_w[ACC_W];
`ifdef ACC_SAT_EN
          acc_d     = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
          acc_d     = sum_w[ACC_W-1:0];
`endif
          add_cnt_d = add_cnt_inc;
          if (add_cnt_inc == num_terms_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered from the next-state values so they
    // carry no combinational path from in_valid or out_ready.
    in_ready_d  = (state_d == ACCUM) && (accept_cnt_d < num_terms_d);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_terms_q  <= '0;
      accept_cnt_q <= '0;
      add_cnt_q    <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      p_q          <= '0;
      p_vld_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_terms_q  <= num_terms_d;
      accept_cnt_q <= accept_cnt_d;
      add_cnt_q    <= add_cnt_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      p_q          <= p_d;
      p_vld_q      <= p_vld_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;

endmodule
